// File: rtl/as2650_bus_responder_if.sv
// Bus-cycle handshake between the as2650 core (master) and a bus responder (slave).
// The core drives the request, cycle qualifiers, address and write data.
// The responder returns read data and the cycle acknowledge.
interface as2650_bus_responder_if;
    logic        opreq;
    logic        rw;
    logic        m_io;
    logic        d_c;
    logic [12:0] adr;
    logic [7:0]  dbus_out;
    logic [7:0]  dbus_in;
    logic        opack;

    modport master (
        output opreq, rw, m_io, d_c, adr, dbus_out,
        input  dbus_in, opack
    );

    modport slave (
        input  opreq, rw, m_io, d_c, adr, dbus_out,
        output dbus_in, opack
    );
endinterface

// File: rtl/as2650_bus_responder.sv
// Bus-cycle responder for the as2650 core.
// Accepts a request, waits a configurable number of cycles (memory or IO), performs
// the access on entry to ACK, and holds opack until the core drops opreq.
// Memory cycles use an internal byte RAM with a registered read; IO cycles use
// N_IO_CH byte-wide channels with output registers and one-cycle strobes.
module as2650_bus_responder #(
    parameter int MEM_AW   = 13,
    parameter int WAIT_MEM = 1,
    parameter int WAIT_IO  = 2,
    parameter int N_IO_CH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    as2650_bus_responder_if.slave  bus,
    output logic [8*N_IO_CH-1:0]   io_out,
    output logic [N_IO_CH-1:0]     io_out_stb,
    input  logic [8*N_IO_CH-1:0]   io_in,
    output logic [N_IO_CH-1:0]     io_rd_stb,
    output logic                   io_dc,
    input  logic                   ld_en,
    input  logic [MEM_AW-1:0]      ld_adr,
    input  logic [7:0]             ld_data,
    output logic                   busy,
    output logic                   abort,
    output logic                   unmapped
);

    localparam int CH_W  = (N_IO_CH > 1) ? $clog2(N_IO_CH) : 1;
    localparam int N_SEL = 1 << CH_W;
    localparam int DEPTH = 1 << MEM_AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        accept;
    logic        enter_ack;
    logic        abort_next;

    // Latched cycle attributes; the access uses these, not the live bus.
    logic [12:0] adr_reg;
    logic        rw_reg;
    logic        mio_reg;
    logic [7:0]  data_reg;
    logic        io_dc_reg;
    logic [7:0]  dbus_in_reg;
    logic        abort_reg;
    logic        unmapped_reg;

    logic [CH_W-1:0] ch;
    logic            io_mapped;
    logic [7:0]      io_in_arr [N_SEL];
    logic [7:0]      io_rd_data;

    logic [7:0]        mem [DEPTH];
    logic [7:0]        ram_q;
    logic              ram_we;
    logic [MEM_AW-1:0] ram_wa;
    logic [MEM_AW-1:0] ram_ra;
    logic [7:0]        ram_wd;

    // FSM next-state: request acceptance, wait countdown, abort and release.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        enter_ack  = 1'b0;
        abort_next = 1'b0;
        case (state_reg)
            IDLE: begin
                // A preload in the same cycle takes priority; the request is taken next clock.
                if (bus.opreq && !ld_en) begin
                    accept     = 1'b1;
                    state_next = WAIT;
                    cnt_next   = bus.m_io ? 4'(WAIT_MEM) : 4'(WAIT_IO);
                end
            end
            WAIT: begin
                if (!bus.opreq) begin
                    abort_next = 1'b1;
                    state_next = IDLE;
                end else if (cnt_reg == 4'd0) begin
                    enter_ack  = 1'b1;
                    state_next = ACK;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ACK: begin
                if (!bus.opreq) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state, countdown and cycle capture registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            adr_reg   <= 13'd0;
            rw_reg    <= 1'b0;
            mio_reg   <= 1'b0;
            data_reg  <= 8'd0;
            io_dc_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                adr_reg  <= bus.adr;
                rw_reg   <= bus.rw;
                mio_reg  <= bus.m_io;
                data_reg <= bus.dbus_out;
                if (!bus.m_io) begin
                    io_dc_reg <= bus.d_c;
                end
            end
        end
    end

    // IO channel decode; any channel index beyond N_IO_CH also counts as unmapped.
    assign ch        = adr_reg[CH_W-1:0];
    assign io_mapped = (adr_reg[7:CH_W] == '0) && ({1'b0, ch} < (CH_W+1)'(N_IO_CH));

    // Write port is shared by preload (IDLE only) and core writes; nothing is written in reset.
    always_comb begin
        ram_we = 1'b0;
        ram_wa = adr_reg[MEM_AW-1:0];
        ram_wd = data_reg;
        if (reset && state_reg == IDLE && ld_en) begin
            ram_we = 1'b1;
            ram_wa = ld_adr;
            ram_wd = ld_data;
        end else if (reset && enter_ack && mio_reg && rw_reg) begin
            ram_we = 1'b1;
        end
    end

    // In IDLE the read address follows the live bus so the data is ready however short the wait.
    assign ram_ra = (state_reg == IDLE) ? bus.adr[MEM_AW-1:0] : adr_reg[MEM_AW-1:0];

    // Byte RAM with registered read (not cleared by reset).
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_wa] <= ram_wd;
        end
        ram_q <= mem[ram_ra];
    end

    // Per-channel IO output registers and strobes; unused select slots read as zero.
    genvar gi;
    generate
        for (gi = 0; gi < N_SEL; gi++) begin : g_sel
            if (gi < N_IO_CH) begin : g_ch
                logic       sel;
                logic [7:0] out_reg;
                logic       out_stb_reg;
                logic       rd_stb_reg;

                assign sel            = !mio_reg && io_mapped && (ch == CH_W'(gi));
                assign io_in_arr[gi]  = io_in[8*gi +: 8];
                assign io_out[8*gi +: 8] = out_reg;
                assign io_out_stb[gi] = out_stb_reg;
                assign io_rd_stb[gi]  = rd_stb_reg;

                // Channel write register and one-cycle write/read strobes at ACK entry.
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        out_reg     <= 8'd0;
                        out_stb_reg <= 1'b0;
                        rd_stb_reg  <= 1'b0;
                    end else begin
                        out_stb_reg <= enter_ack && sel && rw_reg;
                        rd_stb_reg  <= enter_ack && sel && !rw_reg;
                        if (enter_ack && sel && rw_reg) begin
                            out_reg <= data_reg;
                        end
                    end
                end
            end else begin : g_pad
                assign io_in_arr[gi] = 8'd0;
            end
        end
    endgenerate

    assign io_rd_data = io_mapped ? io_in_arr[ch] : 8'hFF;

    // Read data capture and status pulses; dbus_in holds until the next read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dbus_in_reg  <= 8'd0;
            abort_reg    <= 1'b0;
            unmapped_reg <= 1'b0;
        end else begin
            abort_reg    <= abort_next;
            unmapped_reg <= enter_ack && !mio_reg && !io_mapped;
            if (enter_ack && !rw_reg) begin
                dbus_in_reg <= mio_reg ? ram_q : io_rd_data;
            end
        end
    end

    assign bus.dbus_in = dbus_in_reg;
    assign bus.opack   = (state_reg == ACK);
    assign busy        = (state_reg != IDLE);
    assign abort       = abort_reg;
    assign unmapped    = unmapped_reg;
    assign io_dc       = io_dc_reg;

endmodule
